branch_history_ctrl: RTL

Parametrised global-history manager for the branch predictor front end: it keeps a speculative history of HIST_LEN bits, shifts in up to NUM_PRED conditional outcomes per fetch bundle, and checkpoints pre-bundle history in a CKPT_DEPTH ring. It also restores exact history on a mispredict and tracks committed history from NUM_COMMIT retire lanes. It sits between the BTB/TAGE lookup stage (consumer of OUT_history) and the branch resolution / retire logic.

---
 rtl/branch_history_ctrl_pkg.sv | 27 ++
 rtl/branch_history_ctrl_ring.sv | 47 ++++
 rtl/branch_history_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/branch_history_ctrl_pkg.sv
// branch_history_ctrl_pkg: checkpoint entry layout and the shared history shift helper
package branch_history_ctrl_pkg;

    localparam int HIST_MAX  = 64;
    localparam int PRED_MAX  = 8;
    localparam int CNT_MAX_W = 4;

    typedef struct packed {
        logic [HIST_MAX-1:0]  hist;
        logic [PRED_MAX-1:0]  taken;
        logic [CNT_MAX_W-1:0] cnt;
    } ckpt_entry_t;

    // Shifts bits[0..count-1] into history, oldest first, so bits[count-1] lands in bit 0
    function automatic logic [HIST_MAX-1:0] shift_in(
        input logic [HIST_MAX-1:0] history,
        input logic [PRED_MAX-1:0] bits,
        input int                  count
    );
        logic [HIST_MAX-1:0] h;
        h = history;
        for (int i = 0; i < PRED_MAX; i++)
            if (i < count) h = {h[HIST_MAX-2:0], bits[i]};
        return h;
    endfunction

endpackage

// File: rtl/branch_history_ctrl_ring.sv
// history_ckpt_ring: checkpoint register file with head/tail/count bookkeeping
module history_ckpt_ring #(
    parameter int DEPTH = 8,
    parameter int ID_W  = $clog2(DEPTH),
    parameter int W     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            allocEn,
    input  logic [W-1:0]    allocData,
    input  logic            freeEn,
    input  logic            recEn,
    input  logic [ID_W-1:0] recId,
    output logic [W-1:0]    recData,
    output logic [ID_W-1:0] head,
    output logic [ID_W-1:0] tail,
    output logic [ID_W:0]   count,
    output logic            full
);

    logic [W-1:0]    mem [DEPTH];
    logic            doFree;
    logic [ID_W-1:0] headNext;

    assign full     = count == (ID_W+1)'(DEPTH);
    assign doFree   = freeEn && count != '0;
    assign headNext = head + ID_W'(doFree);
    assign recData  = mem[recId];

    // Entry storage; contents only matter once allocated, so no reset
    always_ff @(posedge clk)
        if (allocEn) mem[tail] <= allocData;

    // Recovery trims the ring back to recId (counted from the post-free head); otherwise alloc/free
    always_ff @(posedge clk)
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= headNext;
            tail  <= recEn ? recId + ID_W'(1) : tail + ID_W'(allocEn);
            count <= recEn ? (ID_W+1)'(ID_W'(recId - headNext)) + (ID_W+1)'(1)
                           : count + (ID_W+1)'(allocEn) - (ID_W+1)'(doFree);
        end

endmodule

// File: rtl/branch_history_ctrl.sv
// branch_history_ctrl: speculative/committed global history with checkpointed mispredict recovery
module branch_history_ctrl
    import branch_history_ctrl_pkg::*;
#(
    parameter int HIST_LEN   = 16,
    parameter int NUM_PRED   = 2,
    parameter int NUM_COMMIT = 2,
    parameter int CKPT_DEPTH = 8,
    parameter int CKPT_ID_W  = $clog2(CKPT_DEPTH),
    localparam int CNT_W     = $clog2(NUM_PRED + 1),
    localparam int LANE_W    = NUM_PRED > 1 ? $clog2(NUM_PRED) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IN_predValid,
    input  logic [CNT_W-1:0]      IN_predCnt,
    input  logic [NUM_PRED-1:0]   IN_predTaken,
    output logic                  OUT_predReady,
    output logic [CKPT_ID_W-1:0]  OUT_ckptId,
    output logic [HIST_LEN-1:0]   OUT_history,
    input  logic                  IN_recValid,
    input  logic [CKPT_ID_W-1:0]  IN_recId,
    input  logic [LANE_W-1:0]     IN_recLane,
    input  logic                  IN_recTaken,
    input  logic                  IN_ckptFree,
    input  logic [NUM_COMMIT-1:0] IN_commitValid,
    input  logic [NUM_COMMIT-1:0] IN_commitTaken,
    output logic [HIST_LEN-1:0]   OUT_commitHistory,
    output logic [CKPT_ID_W:0]    OUT_ckptCount
);

    localparam int ENTRY_W = HIST_LEN + NUM_PRED + CNT_W;

    logic                 accept;
    logic                 full;
    logic [CKPT_ID_W-1:0] head;
    logic [ENTRY_W-1:0]   recData;
    logic [HIST_LEN-1:0]  recHist;
    logic [NUM_PRED-1:0]  recTakenVec;
    logic [NUM_PRED-1:0]  recBits;
    logic [CNT_W-1:0]     recCnt;
    logic [HIST_LEN-1:0]  historyNext;
    logic [HIST_LEN-1:0]  commitNext;
    int                   commitN;

    assign OUT_predReady = !full && !IN_recValid;
    assign accept        = IN_predValid && OUT_predReady;
    assign {recHist, recTakenVec, recCnt} = recData;

    history_ckpt_ring #(
        .DEPTH(CKPT_DEPTH),
        .ID_W (CKPT_ID_W),
        .W    (ENTRY_W)
    ) ring (
        .clk      (clk),
        .rst      (rst),
        .allocEn  (accept),
        .allocData({OUT_history, IN_predTaken, IN_predCnt}),
        .freeEn   (IN_ckptFree),
        .recEn    (IN_recValid),
        .recId    (IN_recId),
        .recData  (recData),
        .head     (head),
        .tail     (OUT_ckptId),
        .count    (OUT_ckptCount),
        .full     (full)
    );

    // Replay the stored older lanes, with the resolved outcome in the mispredicted lane
    always_comb begin
        recBits             = recTakenVec;
        recBits[IN_recLane] = IN_recTaken;
    end

    // Next speculative history: a recovery restore beats any new bundle
    always_comb
        historyNext = IN_recValid ? HIST_LEN'(shift_in(HIST_MAX'(recHist), PRED_MAX'(recBits), int'(IN_recLane) + 1))
                    : accept      ? HIST_LEN'(shift_in(HIST_MAX'(OUT_history), PRED_MAX'(IN_predTaken), int'(IN_predCnt)))
                    : OUT_history;

    // Committed lanes are contiguous from lane 0, so their count is the shift amount
    always_comb begin
        commitN = 0;
        for (int i = 0; i < NUM_COMMIT; i++) commitN += int'(IN_commitValid[i]);
        commitNext = HIST_LEN'(shift_in(HIST_MAX'(OUT_commitHistory), PRED_MAX'(IN_commitTaken), commitN));
    end

    // Speculative and committed history registers
    always_ff @(posedge clk)
        if (rst) begin
            OUT_history       <= '0;
            OUT_commitHistory <= '0;
        end else begin
            OUT_history       <= historyNext;
            OUT_commitHistory <= commitNext;
        end

    // Upstream protocol: no free when empty, recovery only on a live checkpoint and an occupied lane
    assert property (@(posedge clk) disable iff (rst) IN_ckptFree |-> OUT_ckptCount != '0);
    assert property (@(posedge clk) disable iff (rst)
        IN_recValid |-> (CKPT_ID_W+1)'(CKPT_ID_W'(IN_recId - head)) < OUT_ckptCount);
    assert property (@(posedge clk) disable iff (rst) IN_recValid |-> CNT_W'(IN_recLane) < recCnt);

endmodule
